bpsk_tx_framer: RTL and testbench
=================================

BPSK_TX_FRAMER -- requirements
Module: bpsk_tx_framer

Interface
REQ-001 Parameter SPS, default 4: samples per symbol, range 1..16.
REQ-002 Parameter PREAMBLE_LEN, default 16: number of preamble symbols, range 1..255.
REQ-003 Parameter PAYLOAD_LEN, default 64: number of payload bytes per frame, range 1..255.
REQ-004 Parameter AMP, default 16'sd23170: BPSK amplitude, Q1.15 positive value.
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  frame request pulse; sampled only in IDLE.
REQ-008 in_valid  in  1  payload byte valid.
REQ-009 in_data  in  8  payload byte, transmitted MSB first.
REQ-010 in_ready  out  1  framer accepts in_data this cycle.
REQ-011 out_valid  out  1  out_sample valid.
REQ-012 out_ready  in  1  downstream receiver (DSP) accepts the sample.
REQ-013 out_sample  out  16  signed Q1.15 sample (`REG_WORD_LEN`).
REQ-014 out_last  out  1  marks the final sample of the frame.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, PREAMBLE, PAYLOAD, DONE.
REQ-017 IDLE with start=1 -> PREAMBLE next cycle; out_valid=1 in that same cycle, carrying preamble symbol 0.
REQ-018 Preamble bits alternate 1,0,1,0... starting with 1; PREAMBLE_LEN symbols.
REQ-019 Symbol mapping: bit 1 -> +AMP, bit 0 -> -AMP; each symbol held for exactly SPS accepted samples.
REQ-020 A sample advances only on out_valid && out_ready; out_sample and out_last are held stable while out_valid && !out_ready.
REQ-021 Payload path is a one-byte holding buffer plus an 8-bit shift register.
REQ-022 in_ready = (state is PREAMBLE or PAYLOAD) && buffer empty && bytes_accepted < PAYLOAD_LEN; bytes may therefore be prefetched during the preamble.
REQ-023 The shift register loads from the buffer at each byte boundary; a byte accepted while the shift register empties is visible to the shift register no earlier than the next cycle.
REQ-024 Underrun (byte needed, buffer empty): out_valid=0 until a byte arrives; no sample is skipped or duplicated.
REQ-025 PREAMBLE -> PAYLOAD on acceptance of the last preamble sample.
REQ-026 PAYLOAD -> DONE on acceptance of the last sample (sample index PAYLOAD_LEN*8*SPS-1).
REQ-027 out_last=1 only with that last sample.
REQ-028 DONE lasts one cycle with out_valid=0, then -> IDLE.
REQ-029 start outside IDLE is ignored.
REQ-030 start and rst in the same cycle: rst wins.
REQ-031 Counters (sample-in-symbol, symbol, byte) wrap to 0 at each boundary and are sized for the maximum parameter values.
REQ-032 No arithmetic saturation is needed: out_sample is always exactly +AMP or -AMP.

Reset
REQ-033 rst=1 -> state IDLE; out_valid=0, out_sample=0, out_last=0, in_ready=0, busy=0; buffer empty; all counters 0.
REQ-034 Reset mid-frame aborts the frame with no partial out_last; a byte presented during reset is not accepted.

Structure
REQ-035 State encodings (TX_IDLE, TX_PREAMBLE, TX_PAYLOAD, TX_DONE) and the sample width (`REG_WORD_LEN`) live in definitions.v.
REQ-036 The combinational bit-to-sample map is the sub-module bpsk_mapper (bit, AMP -> sample); all other logic lives in bpsk_tx_framer.

Verification (SPS=4, PREAMBLE_LEN=2, PAYLOAD_LEN=1, AMP=16384 unless stated)
REQ-037 Basic frame: start, byte 0xA5 offered at once, out_ready=1 -> 40 samples: +16384x4, -16384x4, then bits 1,0,1,0,0,1,0,1 each x4; out_last only on sample 40; busy falls 2 cycles after sample 40.
REQ-038 Backpressure: out_ready=0 for 5 cycles at sample 6 -> sample 6 (-16384) held; total still 40 samples, none lost or repeated.
REQ-039 Underrun: in_valid withheld until 10 cycles after the preamble ends -> out_valid=0 during the gap; payload resumes with +16384.
REQ-040 Reset at sample 20 -> next cycle out_valid=0, busy=0, in_ready=0; a fresh start yields a full 40-sample frame.
REQ-041 start pulses during a frame -> ignored; exactly one frame produced.
REQ-042 PAYLOAD_LEN=3, bytes 0xFF,0x00,0x81 with in_valid always high -> no bubble after the first sample; 104 samples; out_last on sample 104.

Source files
------------

// File: rtl/bpsk_tx_framer_pkg.sv
// Shared definitions for the BPSK transmit framer.
// Holds the sample word width and the framer state encodings.
// No ports; imported by bpsk_mapper and bpsk_tx_framer.
package bpsk_tx_framer_pkg;

  localparam int REG_WORD_LEN = 16;

  typedef enum logic [1:0] {
    TX_IDLE     = 2'd0,
    TX_PREAMBLE = 2'd1,
    TX_PAYLOAD  = 2'd2,
    TX_DONE     = 2'd3
  } tx_state_t;

endpackage

// File: rtl/bpsk_mapper.sv
// BPSK bit-to-sample map: bit 1 -> +amp, bit 0 -> -amp.
// Latency: purely combinational. Backpressure: none, no state.
// Ports: i_bit (symbol bit), i_amp (positive Q1.15 amplitude), o_sample (signed Q1.15).
module bpsk_mapper
  import bpsk_tx_framer_pkg::*;
(
  input  logic                           i_bit,
  input  logic signed [REG_WORD_LEN-1:0] i_amp,
  output logic signed [REG_WORD_LEN-1:0] o_sample
);

  // i_amp is always positive, so negation cannot overflow.
  assign o_sample = i_bit ? i_amp : -i_amp;

endmodule

// File: rtl/bpsk_tx_framer.sv
// BPSK frame transmitter: alternating preamble then payload bytes MSB first, SPS samples per symbol.
// Latency: first preamble sample valid the cycle after start; payload bytes pass a 1-byte buffer + shift register.
// Backpressure: samples advance only on out_valid && out_ready; out_valid drops on payload underrun.
// Ports: clk/rst (sync, active high), start, in_valid/in_data/in_ready (byte input),
//        out_valid/out_ready/out_sample/out_last (sample output), busy (not idle).
module bpsk_tx_framer
  import bpsk_tx_framer_pkg::*;
#(
  parameter int                           SPS          = 4,
  parameter int                           PREAMBLE_LEN = 16,
  parameter int                           PAYLOAD_LEN  = 64,
  parameter logic signed [REG_WORD_LEN-1:0] AMP        = 16'sd23170
)(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           in_valid,
  input  logic [7:0]                     in_data,
  output logic                           in_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [REG_WORD_LEN-1:0] out_sample,
  output logic                           out_last,
  output logic                           busy
);

  localparam logic [3:0] SPS_M1  = 4'(SPS - 1);
  localparam logic [7:0] PRE_M1  = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0] PAY_M1  = 8'(PAYLOAD_LEN - 1);
  localparam logic [7:0] PAY_LEN = 8'(PAYLOAD_LEN);

  tx_state_t r_state;
  tx_state_t w_state_nxt;

  logic [3:0] r_samp_cnt;   // sample within symbol
  logic [7:0] r_sym_cnt;    // preamble symbol index, or bit index within byte
  logic [7:0] r_byte_cnt;   // payload bytes transmitted
  logic [7:0] r_bytes_acc;  // payload bytes accepted from the input
  logic [7:0] r_buf;
  logic       r_buf_full;
  logic [7:0] r_sr;
  logic       r_sr_vld;

  logic w_out_vld, w_fire, w_sym_end, w_pre_last, w_bit_end, w_byte_end, w_frame_last;
  logic w_in_acc, w_load, w_bit;
  logic signed [REG_WORD_LEN-1:0] w_map;

  assign w_out_vld    = (r_state == TX_PREAMBLE) || ((r_state == TX_PAYLOAD) && r_sr_vld);
  assign w_fire       = w_out_vld && out_ready;
  assign w_sym_end    = w_fire && (r_samp_cnt == SPS_M1);
  assign w_pre_last   = (r_state == TX_PREAMBLE) && w_sym_end && (r_sym_cnt == PRE_M1);
  assign w_bit_end    = (r_state == TX_PAYLOAD) && w_sym_end;
  assign w_byte_end   = w_bit_end && (r_sym_cnt == 8'd7);
  assign w_frame_last = w_byte_end && (r_byte_cnt == PAY_M1);

  assign in_ready = ((r_state == TX_PREAMBLE) || (r_state == TX_PAYLOAD)) &&
                    !r_buf_full && (r_bytes_acc < PAY_LEN);
  assign w_in_acc = in_valid && in_ready;

  // Refill the shift register straight from the buffer at a byte boundary so a
  // full buffer gives back-to-back bytes; otherwise refill once the buffer fills.
  assign w_load = r_buf_full &&
                  (w_pre_last || (w_byte_end && !w_frame_last) ||
                   ((r_state == TX_PAYLOAD) && !r_sr_vld));

  // Preamble alternates 1,0,1,0... starting from symbol 0.
  assign w_bit = (r_state == TX_PREAMBLE) ? ~r_sym_cnt[0] : r_sr[7];

  bpsk_mapper u_mapper (
    .i_bit    (w_bit),
    .i_amp    (AMP),
    .o_sample (w_map)
  );

  assign out_valid  = w_out_vld;
  assign out_sample = w_out_vld ? w_map : '0;
  assign out_last   = (r_state == TX_PAYLOAD) && r_sr_vld && (r_samp_cnt == SPS_M1) &&
                      (r_sym_cnt == 8'd7) && (r_byte_cnt == PAY_M1);
  assign busy       = (r_state != TX_IDLE);

  always_ff @(posedge clk) begin
    if (rst) r_state <= TX_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      TX_IDLE:     if (start)        w_state_nxt = TX_PREAMBLE;
      TX_PREAMBLE: if (w_pre_last)   w_state_nxt = TX_PAYLOAD;
      TX_PAYLOAD:  if (w_frame_last) w_state_nxt = TX_DONE;
      TX_DONE:                       w_state_nxt = TX_IDLE;
      default:                       w_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || (r_state == TX_DONE)) begin
      r_samp_cnt  <= '0;
      r_sym_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_bytes_acc <= '0;
      r_buf       <= '0;
      r_buf_full  <= 1'b0;
      r_sr        <= '0;
      r_sr_vld    <= 1'b0;
    end else begin
      if (w_in_acc) begin
        r_buf       <= in_data;
        r_buf_full  <= 1'b1;
        r_bytes_acc <= r_bytes_acc + 8'd1;
      end

      // w_load needs a full buffer and w_in_acc needs an empty one: never both.
      if (w_load) begin
        r_sr       <= r_buf;
        r_sr_vld   <= 1'b1;
        r_buf_full <= 1'b0;
      end else if (w_byte_end) begin
        r_sr_vld <= 1'b0;
      end else if (w_bit_end) begin
        r_sr <= {r_sr[6:0], 1'b0};
      end

      if (w_fire)
        r_samp_cnt <= (r_samp_cnt == SPS_M1) ? 4'd0 : r_samp_cnt + 4'd1;

      if (w_pre_last || w_byte_end) r_sym_cnt <= '0;
      else if (w_sym_end)           r_sym_cnt <= r_sym_cnt + 8'd1;

      if (w_frame_last)    r_byte_cnt <= '0;
      else if (w_byte_end) r_byte_cnt <= r_byte_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_bpsk_tx_framer.sv
module tb_bpsk_tx_framer;

  localparam int SPS = 4;
  localparam int PRE = 2;
  localparam logic signed [15:0] AMP  = 16'sd16384;
  localparam logic signed [15:0] NAMP = -16'sd16384;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [7:0] in_data;
  logic signed [15:0] out_sample;

  logic b_start, b_in_valid, b_in_ready, b_out_valid, b_out_last, b_busy;
  logic [7:0] b_in_data;
  logic signed [15:0] b_out_sample;

  bpsk_tx_framer #(.SPS(SPS), .PREAMBLE_LEN(PRE), .PAYLOAD_LEN(1), .AMP(AMP)) dut_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_sample(out_sample), .out_last(out_last), .busy(busy));

  bpsk_tx_framer #(.SPS(SPS), .PREAMBLE_LEN(PRE), .PAYLOAD_LEN(3), .AMP(AMP)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_sample(b_out_sample), .out_last(b_out_last), .busy(b_busy));

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A byte feeder: main appends to feed_mem, this process owns the read index.
  logic [7:0] feed_mem [16];
  int  feed_total = 0;
  bit  feed_en = 1'b1;
  int  feed_idx;
  initial begin
    bit hs;
    in_valid = 1'b0; in_data = 8'h00; feed_idx = 0;
    forever begin
      @(negedge clk); hs = in_valid && in_ready;
      @(posedge clk); #2;
      if (hs) feed_idx++;
      in_valid = feed_en && (feed_idx < feed_total);
      in_data  = (feed_idx < feed_total) ? feed_mem[feed_idx] : 8'h00;
    end
  end

  // DUT B byte feeder: in_valid permanently high, bytes FF,00,81.
  initial begin
    bit hs;
    int idx;
    idx = 0; b_in_valid = 1'b1; b_in_data = 8'hFF;
    forever begin
      @(negedge clk); hs = b_in_valid && b_in_ready;
      @(posedge clk); #2;
      if (hs) idx++;
      case (idx)
        0: b_in_data = 8'hFF;
        1: b_in_data = 8'h00;
        2: b_in_data = 8'h81;
        default: b_in_data = 8'h00;
      endcase
    end
  end

  // Collectors: record each accepted sample at the negedge preceding its edge.
  logic signed [15:0] got_q[$];
  bit last_q[$];
  int last_cyc = 0, fall_cyc = 0;
  logic busy_d = 1'b0;
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got_q.push_back(out_sample);
      last_q.push_back(out_last);
      if (out_last) last_cyc = cyc;
    end
    if (busy_d && !busy) fall_cyc = cyc;
    busy_d = busy;
  end

  logic signed [15:0] bq[$];
  bit blast_q[$];
  int b_bubbles = 0;
  bit b_seen = 1'b0;
  always @(negedge clk) begin
    if (!rst && b_out_valid && out_ready) begin
      bq.push_back(b_out_sample);
      blast_q.push_back(b_out_last);
      b_seen = 1'b1;
    end else if (b_seen && b_busy && bq.size() < 104) begin
      b_bubbles++;
    end
  end

  logic signed [15:0] exp_q[$];

  task automatic build_exp(input int nby, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] bs [3];
    bs[0] = b0; bs[1] = b1; bs[2] = b2;
    exp_q.delete();
    for (int s = 0; s < PRE; s++)
      for (int k = 0; k < SPS; k++) exp_q.push_back((s % 2 == 0) ? AMP : NAMP);
    for (int i = 0; i < nby; i++)
      for (int j = 7; j >= 0; j--)
        for (int k = 0; k < SPS; k++) exp_q.push_back(bs[i][j] ? AMP : NAMP);
  endtask

  function automatic logic signed [15:0] got_at(input int i);
    if (i < got_q.size()) return got_q[i];
    return 16'hxxxx;
  endfunction

  task automatic wait_n(input int base, input int n, input int budget);
    int k = 0;
    while ((got_q.size() - base < n) && (k < budget)) begin
      @(posedge clk); #1; k++;
    end
  endtask

  task automatic check_frame(input string tag, input int base, input int n_exp);
    int bad = 0, nlast = 0, lastidx = -1;
    check({tag, "_count"}, got_q.size() - base, n_exp);
    for (int i = 0; (base + i < got_q.size()) && (i < exp_q.size()); i++) begin
      if (got_q[base + i] !== exp_q[i]) bad++;
      if (last_q[base + i]) begin nlast++; lastidx = i; end
    end
    check({tag, "_seq_bad"}, bad, 0);
    check({tag, "_last_cnt"}, nlast, 1);
    check({tag, "_last_idx"}, lastidx, n_exp - 1);
  endtask

  task automatic launch(input logic [7:0] b);
    @(posedge clk); #1;
    start = 1'b1;
    feed_mem[feed_total] = b;
    feed_total++;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, vcnt, nl;
    rst = 1'b1; start = 1'b0; out_ready = 1'b1; b_start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sample", out_sample, 0);
    check("rst_out_last", out_last, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Basic frame: 0xA5 offered at once.
    build_exp(1, 8'hA5, 8'h00, 8'h00);
    base = got_q.size();
    launch(8'hA5);
    check("basic_first_valid", out_valid, 1);
    check("basic_first_sample", out_sample, AMP);
    check("basic_busy", busy, 1);
    wait_n(base, 40, 200);
    repeat (4) @(posedge clk); #1;
    check_frame("basic", base, 40);
    check("basic_s4", got_at(base + 4), NAMP);
    check("basic_s8", got_at(base + 8), AMP);
    check("basic_s12", got_at(base + 12), NAMP);
    check("basic_s36", got_at(base + 36), AMP);
    check("basic_busy_fall", fall_cyc - last_cyc, 2);

    // Backpressure on sample 6.
    base = got_q.size();
    launch(8'hA5);
    wait_n(base, 5, 100);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_sample", out_sample, NAMP);
    end
    check("bp_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    wait_n(base, 40, 200);
    repeat (4) @(posedge clk); #1;
    check_frame("bp", base, 40);

    // Underrun: byte withheld until 10 cycles after the preamble.
    feed_en = 1'b0;
    base = got_q.size();
    launch(8'hA5);
    wait_n(base, 8, 100);
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) vcnt++;
    end
    check("ur_gap_valid_cnt", vcnt, 0);
    check("ur_in_ready", in_ready, 1);
    @(posedge clk); #1 feed_en = 1'b1;
    wait_n(base, 40, 200);
    repeat (4) @(posedge clk); #1;
    check_frame("ur", base, 40);
    check("ur_payload_first", got_at(base + 8), AMP);

    // Reset at sample 20, then a fresh frame.
    base = got_q.size();
    launch(8'hA5);
    wait_n(base, 20, 100);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    nl = 0;
    for (int i = base; i < got_q.size(); i++) if (last_q[i]) nl++;
    check("mid_rst_no_last", nl, 0);
    repeat (2) @(posedge clk);
    base = got_q.size();
    launch(8'hA5);
    wait_n(base, 40, 200);
    repeat (4) @(posedge clk); #1;
    check_frame("after_rst", base, 40);

    // Start pulses during a frame are ignored.
    base = got_q.size();
    launch(8'hA5);
    for (int k = 0; (k < 200) && (got_q.size() - base < 40); k++) begin
      @(posedge clk); #1;
      start = (k == 3) || (k == 15) || (k == 30);
    end
    start = 1'b0;
    repeat (30) @(posedge clk); #1;
    check_frame("ign_start", base, 40);
    check("ign_start_idle", busy, 0);

    // PAYLOAD_LEN=3, in_valid always high.
    build_exp(3, 8'hFF, 8'h00, 8'h81);
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    for (int k = 0; (k < 400) && (bq.size() < 104); k++) begin
      @(posedge clk); #1;
    end
    repeat (4) @(posedge clk); #1;
    check("b_count", bq.size(), 104);
    begin
      int bad = 0, nlb = 0, li = -1;
      for (int i = 0; (i < bq.size()) && (i < exp_q.size()); i++) begin
        if (bq[i] !== exp_q[i]) bad++;
        if (blast_q[i]) begin nlb++; li = i; end
      end
      check("b_seq_bad", bad, 0);
      check("b_last_cnt", nlb, 1);
      check("b_last_idx", li, 103);
    end
    check("b_bubbles", b_bubbles, 0);
    check("b_idle", b_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
